// File: rtl/regfile_writeback.sv
// Writeback queue in front of the register file write port. Buffers results and
// ecall markers in program order, retires one per cycle and sequences ecall handshakes.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_ecall,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_value,
  output logic            rf_write_enable,
  output logic [4:0]      rf_write_register,
  output logic [XLEN-1:0] rf_write_value,
  input  logic            rf_write_ready,
  output logic            rf_ecall,
  input  logic            rf_ecall_done,
  output logic            ecall_complete,
  input  logic [4:0]      query_reg,
  output logic            query_hit,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic            ecall;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ECALL_WAIT, ECALL_RELEASE} state_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  state_t           state, state_nxt;
  logic             push, store, pop, empty;
  entry_t           head;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  // writes to x0 are architecturally dead, so they are acknowledged but never queued
  assign store    = push && (in_ecall || (in_rd != 5'd0));
  assign head     = mem[rd_ptr];

  always_comb begin
    state_nxt         = state;
    pop               = 1'b0;
    rf_write_enable   = 1'b0;
    rf_write_register = '0;
    rf_write_value    = '0;
    rf_ecall          = 1'b0;
    ecall_complete    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          if (head.ecall) begin
            state_nxt = ECALL_WAIT;
          end else begin
            rf_write_enable   = 1'b1;
            rf_write_register = head.rd;
            rf_write_value    = head.value;
            pop               = rf_write_ready;
          end
        end
      end
      ECALL_WAIT: begin
        rf_ecall = 1'b1;
        if (rf_ecall_done) begin
          pop       = 1'b1;
          state_nxt = ECALL_RELEASE;
        end
      end
      ECALL_RELEASE: begin
        // one quiet cycle so the register file's ecall FSM can return to idle
        ecall_complete = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      state <= state_nxt;
      if (store) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= '{ecall: in_ecall, rd: in_rd, value: in_value};
  end

  // an ecall clobbers a0 with its return value, so it hazards against x10
  logic [DEPTH-1:0] hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = vld[i] && (mem[i].ecall ? (query_reg == 5'd10) : (mem[i].rd == query_reg));
  end
  assign query_hit = (query_reg != 5'd0) && (|hit);

  assign busy = !empty || (state != IDLE);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based behavioural model.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_ecall;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_value;
  logic            rf_write_enable, rf_write_ready, rf_ecall, rf_ecall_done, ecall_complete;
  logic [4:0]      rf_write_register, query_reg;
  logic [XLEN-1:0] rf_write_value;
  logic            query_hit, busy;

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ecall(in_ecall),
    .in_rd(in_rd), .in_value(in_value), .rf_write_enable(rf_write_enable),
    .rf_write_register(rf_write_register), .rf_write_value(rf_write_value),
    .rf_write_ready(rf_write_ready), .rf_ecall(rf_ecall), .rf_ecall_done(rf_ecall_done),
    .ecall_complete(ecall_complete), .query_reg(query_reg), .query_hit(query_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ecall;
    bit [4:0]  rd;
    bit [63:0] value;
  } ent_t;

  ent_t q[$];
  int   phase;   // 0 idle, 1 waiting on ecall done, 2 release cycle
  int   n_chk = 0;
  int   n_pass = 0;
  bit   did_rst = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit model_hit(input bit [4:0] r);
    if (r == 0) return 1'b0;
    foreach (q[i]) begin
      if (q[i].ecall && r == 5'd10) return 1'b1;
      if (!q[i].ecall && q[i].rd == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    bit exp_we;
    exp_we = (phase == 0) && (q.size() > 0) && !q[0].ecall;
    check("in_ready", in_ready, q.size() < DEPTH);
    check("we", rf_write_enable, exp_we);
    if (exp_we) begin
      check("wreg", rf_write_register, q[0].rd);
      check("wval", rf_write_value, q[0].value);
    end
    check("rf_ecall", rf_ecall, phase == 1);
    check("ecall_complete", ecall_complete, phase == 2);
    check("busy", busy, (q.size() > 0) || (phase != 0));
    check("query_hit", query_hit, model_hit(query_reg));
  endtask

  task automatic model_step();
    bit can_push;
    can_push = in_valid && (q.size() < DEPTH);
    case (phase)
      0: if (q.size() > 0) begin
           if (q[0].ecall) phase = 1;
           else if (rf_write_ready) void'(q.pop_front());
         end
      1: if (rf_ecall_done) begin void'(q.pop_front()); phase = 2; end
      default: phase = 0;
    endcase
    if (can_push && (in_ecall || in_rd != 0))
      q.push_back('{ecall: in_ecall, rd: in_rd, value: in_value});
  endtask

  task automatic reset_mid_run();
    reset = 1'b0;
    in_valid = 1'b1; in_ecall = 1'b0; in_rd = 5'd7; query_reg = 5'd7;
    #1;
    check("rst_rf_ecall", rf_ecall, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_we", rf_write_enable, 1'b0);
    check("rst_hit", query_hit, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    phase = 0;
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_we", rf_write_enable, 1'b0);
  endtask

  initial begin
    int vp, rp;
    reset = 1'b0; in_valid = 1'b0; in_ecall = 1'b0; in_rd = '0; in_value = '0;
    rf_write_ready = 1'b0; rf_ecall_done = 1'b0; query_reg = '0;
    phase = 0;
    #3;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_we", rf_write_enable, 1'b0);
    check("reset_ecall", rf_ecall, 1'b0);
    check("reset_complete", ecall_complete, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_hit", query_hit, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!did_rst && cyc > 1500 && phase == 1 && q.size() > 0) begin
        did_rst = 1'b1;
        reset_mid_run();
        continue;
      end
      case ((cyc / 400) % 4)
        0:       begin vp = 70; rp = 90;  end
        1:       begin vp = 90; rp = 20;  end
        2:       begin vp = 30; rp = 100; end
        default: begin vp = 80; rp = 60;  end
      endcase
      in_valid       = ($urandom_range(0, 99) < vp);
      in_ecall       = ($urandom_range(0, 99) < 15);
      in_rd          = 5'($urandom_range(0, 15));
      in_value       = {32'($urandom), 32'($urandom)};
      rf_write_ready = ($urandom_range(0, 99) < rp);
      rf_ecall_done  = ($urandom_range(0, 99) < 40);
      query_reg      = ($urandom_range(0, 9) == 0) ? 5'd10 : 5'($urandom_range(0, 15));
      #1;
      check_outputs();
      model_step();
    end
    if (!did_rst) check("mid_ecall_reset_reached", 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
